// File: rtl/seg_display_decoder_if.sv
// Bus between a two-digit multiplexed 7-segment driver and its decoder/monitor.
// The master drives the display pins; the slave reports the reconstructed value.
interface seg_display_decoder_if;
    logic [7:0] seg_in;
    logic       disp1_in;
    logic       disp2_in;
    logic [7:0] value;
    logic       value_valid;
    logic       overflow;
    logic       code_err;
    logic       timeout_err;
    logic [7:0] frame_cnt;

    modport master (
        output seg_in, disp1_in, disp2_in,
        input  value, value_valid, overflow, code_err, timeout_err, frame_cnt
    );

    modport slave (
        input  seg_in, disp1_in, disp2_in,
        output value, value_valid, overflow, code_err, timeout_err, frame_cnt
    );
endinterface

// File: rtl/seg_display_decoder.sv
// Watches a multiplexed two-digit active-low 7-segment bus, filters transients,
// decodes the digits and rebuilds the displayed 8-bit value (tens*10+ones).
module seg_display_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int TIMEOUT       = 1024
) (
    input logic                clk,
    input logic                rst,
    seg_display_decoder_if.slave bus
);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [3:0] D_BLANK   = 4'hA;
    localparam logic [3:0] D_ILLEGAL = 4'hF;

    typedef enum logic [1:0] {SEL_NONE = 2'b00, SEL_ONES = 2'b01, SEL_TENS = 2'b10} sel_t;
    typedef enum logic {S_ONES = 1'b0, S_TENS = 1'b1} state_t;

    function automatic logic [3:0] decode(input logic [7:0] code);
        case (code)
            8'h81:   decode = 4'd0;
            8'hCF:   decode = 4'd1;
            8'h92:   decode = 4'd2;
            8'h86:   decode = 4'd3;
            8'hCC:   decode = 4'd4;
            8'hA4:   decode = 4'd5;
            8'hA0:   decode = 4'd6;
            8'h8F:   decode = 4'd7;
            8'h80:   decode = 4'd8;
            8'h84:   decode = 4'd9;
            8'hFF:   decode = D_BLANK;
            default: decode = D_ILLEGAL;
        endcase
    endfunction

    function automatic sel_t select(input logic d1_n, input logic d2_n);
        if (!d1_n && d2_n)      select = SEL_ONES;
        else if (d1_n && !d2_n) select = SEL_TENS;
        else                    select = SEL_NONE;
    endfunction

    logic [7:0]   r_seg_p0, r_seg_p1;
    sel_t         r_sel_p0, r_sel_p1;
    logic [SW-1:0] r_stab;
    logic         w_same, w_accept;
    logic [3:0]   w_digit;

    // Stage p0: register the raw pins; stage p1: previous sample for comparison
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg_p0 <= '0;
            r_sel_p0 <= SEL_NONE;
            r_seg_p1 <= '0;
            r_sel_p1 <= SEL_NONE;
        end else begin
            r_seg_p0 <= bus.seg_in;
            r_sel_p0 <= select(bus.disp1_in, bus.disp2_in);
            r_seg_p1 <= r_seg_p0;
            r_sel_p1 <= r_sel_p0;
        end
    end

    assign w_same = (r_sel_p0 == r_sel_p1) && (r_seg_p0 == r_seg_p1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                 r_stab <= '0;
        else if (!w_same)                        r_stab <= SW'(1);
        else if (r_stab != SW'(STABLE_CYCLES))   r_stab <= r_stab + 1'b1;
    end

    // Fires only on the step into saturation, so a held digit is accepted once
    assign w_accept = w_same && (r_stab == SW'(STABLE_CYCLES - 1)) && (r_sel_p0 != SEL_NONE);
    assign w_digit  = decode(r_seg_p0);

    state_t        r_state, w_state_n;
    logic [3:0]    r_ones, w_ones_n;
    logic [TW-1:0] r_tmo, w_tmo_n;
    logic [7:0]    r_value, w_value_n, r_frame, w_frame_n;
    logic          r_ovf, w_ovf_n, r_valid, w_valid_n;
    logic          r_cerr, w_cerr_n, r_terr, w_terr_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_ONES;
            r_ones  <= '0;
            r_tmo   <= '0;
            r_value <= '0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
            r_cerr  <= 1'b0;
            r_terr  <= 1'b0;
            r_frame <= '0;
        end else begin
            r_state <= w_state_n;
            r_ones  <= w_ones_n;
            r_tmo   <= w_tmo_n;
            r_value <= w_value_n;
            r_ovf   <= w_ovf_n;
            r_valid <= w_valid_n;
            r_cerr  <= w_cerr_n;
            r_terr  <= w_terr_n;
            r_frame <= w_frame_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_ones_n  = r_ones;
        w_tmo_n   = r_tmo;
        w_value_n = r_value;
        w_ovf_n   = r_ovf;
        w_valid_n = 1'b0;
        w_cerr_n  = 1'b0;
        w_terr_n  = 1'b0;
        w_frame_n = r_frame;
        case (r_state)
            S_ONES: begin
                w_tmo_n = '0;
                if (w_accept && r_sel_p0 == SEL_ONES) begin
                    if (w_digit < 4'd10) begin
                        w_ones_n  = w_digit;
                        w_state_n = S_TENS;
                    end else begin
                        w_cerr_n = 1'b1;
                    end
                end
            end
            S_TENS: begin
                if (w_accept && r_sel_p0 == SEL_TENS) begin
                    w_state_n = S_ONES;
                    if (w_digit < 4'd10) begin
                        w_value_n = ({4'b0, w_digit} * 8'd10) + {4'b0, r_ones};
                        w_ovf_n   = 1'b0;
                        w_valid_n = 1'b1;
                        w_frame_n = r_frame + 8'd1;
                    end else if (w_digit == D_BLANK) begin
                        // Blank tens is how the driver renders tens digits 10..15
                        w_value_n = {4'b0, r_ones};
                        w_ovf_n   = 1'b1;
                        w_valid_n = 1'b1;
                        w_frame_n = r_frame + 8'd1;
                    end else begin
                        w_cerr_n = 1'b1;
                    end
                end else if (w_accept) begin
                    if (w_digit < 4'd10) begin
                        w_ones_n = w_digit;
                        w_tmo_n  = '0;
                    end else begin
                        w_cerr_n  = 1'b1;
                        w_state_n = S_ONES;
                    end
                end else if (r_tmo == TW'(TIMEOUT - 1)) begin
                    w_terr_n  = 1'b1;
                    w_state_n = S_ONES;
                end else begin
                    w_tmo_n = r_tmo + 1'b1;
                end
            end
            default: w_state_n = S_ONES;
        endcase
    end

    assign bus.value       = r_value;
    assign bus.value_valid = r_valid;
    assign bus.overflow    = r_ovf;
    assign bus.code_err    = r_cerr;
    assign bus.timeout_err = r_terr;
    assign bus.frame_cnt   = r_frame;
endmodule

// File: tb/tb_seg_display_decoder.sv
// Directed bench for seg_display_decoder: table of ones/tens frames plus
// hand sequences for glitch rejection, timeout, async reset and frame_cnt wrap.
module tb_seg_display_decoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg_display_decoder_if bus();
    seg_display_decoder #(.STABLE_CYCLES(4), .TIMEOUT(1024)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int total = 0, bad = 0;
    int edge_cnt = 0;
    int n_valid = 0, n_cerr = 0, n_terr = 0, n_multi = 0;
    int last_v = 0, last_t = 0;

    always @(posedge clk) edge_cnt++;
    always @(posedge clk) begin
        #1;
        if (bus.value_valid) begin n_valid++; last_v = edge_cnt; end
        if (bus.code_err)    n_cerr++;
        if (bus.timeout_err) begin n_terr++; last_t = edge_cnt; end
        if (int'(bus.value_valid) + int'(bus.code_err) + int'(bus.timeout_err) > 1) n_multi++;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // sel: 0=NONE, 1=ONES, 2=TENS
    task automatic hold(input logic [7:0] seg, input int sel, input int n, output int t0);
        @(negedge clk);
        bus.seg_in   = seg;
        bus.disp1_in = (sel == 1) ? 1'b0 : 1'b1;
        bus.disp2_in = (sel == 2) ? 1'b0 : 1'b1;
        t0 = edge_cnt;
        repeat (n) @(posedge clk);
    endtask

    task automatic frame(input logic [7:0] o, input logic [7:0] t, input int n, output int t_tens);
        int tmp;
        hold(o, 1, n, tmp);
        hold(t, 2, n, t_tens);
        hold(8'hFF, 0, 2, tmp);
        @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] ones_seg;
        logic [7:0] tens_seg;
        int ev;
        int ecerr;
        int evalue;
        int eovf;
    } rec_t;

    rec_t tab[8];
    logic [7:0] seg_tab [10];

    initial begin
        int tt, tmp, v0, c0, t0, exp_frame, k;
        seg_tab = '{8'h81, 8'hCF, 8'h92, 8'h86, 8'hCC, 8'hA4, 8'hA0, 8'h8F, 8'h80, 8'h84};
        tab[0] = '{8'h86, 8'hCC, 1, 0, 43, 0};
        tab[1] = '{8'h84, 8'h92, 1, 0, 29, 0};
        tab[2] = '{8'h81, 8'hFF, 1, 0,  0, 1};
        tab[3] = '{8'h8F, 8'h55, 0, 1,  0, 1};
        tab[4] = '{8'h80, 8'h84, 1, 0, 98, 0};
        tab[5] = '{8'hCF, 8'h81, 1, 0,  1, 0};
        tab[6] = '{8'h55, 8'hCC, 0, 1,  1, 0};
        tab[7] = '{8'hA0, 8'hCF, 1, 0, 16, 0};

        bus.seg_in = 8'hFF; bus.disp1_in = 1'b1; bus.disp2_in = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_value", bus.value, 0);
        chk("reset_frame", bus.frame_cnt, 0);
        chk("reset_pulses", {bus.value_valid, bus.code_err, bus.timeout_err, bus.overflow}, 0);
        rst = 1'b0;
        exp_frame = 0;

        foreach (tab[i]) begin
            v0 = n_valid; c0 = n_cerr;
            frame(tab[i].ones_seg, tab[i].tens_seg, 6, tt);
            exp_frame += tab[i].ev;
            chk($sformatf("rec%0d_valid", i), n_valid - v0, tab[i].ev);
            chk($sformatf("rec%0d_cerr", i), n_cerr - c0, tab[i].ecerr);
            chk($sformatf("rec%0d_value", i), bus.value, tab[i].evalue);
            chk($sformatf("rec%0d_ovf", i), bus.overflow, tab[i].eovf);
            chk($sformatf("rec%0d_frame", i), bus.frame_cnt, exp_frame);
            if (tab[i].ev != 0) chk($sformatf("rec%0d_latency", i), last_v - tt, 5);
        end

        // Short ones glitch must not be captured
        v0 = n_valid;
        hold(8'hA4, 1, 3, tmp);
        hold(8'h92, 2, 6, tmp);
        hold(8'hFF, 0, 2, tmp);
        @(negedge clk);
        chk("glitch_no_capture", n_valid - v0, 0);
        hold(8'hA4, 1, 3, tmp);
        hold(8'h84, 1, 6, tmp);
        hold(8'h92, 2, 6, tt);
        hold(8'hFF, 0, 2, tmp);
        @(negedge clk);
        exp_frame++;
        chk("glitch_valid", n_valid - v0, 1);
        chk("glitch_value", bus.value, 29);

        // Timeout: ones captured on the 5th edge, error 1024 edges later
        v0 = n_valid;
        hold(8'h80, 1, 6, t0);
        hold(8'hFF, 0, 1100, tmp);
        @(negedge clk);
        chk("tmo_count", n_terr, 1);
        chk("tmo_edge", last_t - t0, 1029);
        chk("tmo_no_valid", n_valid - v0, 0);
        chk("tmo_frame", bus.frame_cnt, exp_frame);

        // Asynchronous reset mid-frame discards captured ones
        hold(8'h86, 1, 6, tmp);
        @(negedge clk);
        bus.seg_in = 8'hCC; bus.disp1_in = 1'b1; bus.disp2_in = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        bus.seg_in = 8'h92;
        #1;
        chk("arst_value", bus.value, 0);
        chk("arst_frame", bus.frame_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        v0 = n_valid;
        hold(8'hCC, 2, 6, tmp);
        hold(8'hFF, 0, 2, tmp);
        @(negedge clk);
        chk("arst_need_ones", n_valid - v0, 0);
        frame(8'h86, 8'hCC, 6, tt);
        chk("arst_value43", bus.value, 43);
        chk("arst_frame1", bus.frame_cnt, 1);

        // frame_cnt wrap
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        v0 = n_valid;
        for (int f = 0; f < 256; f++) begin
            frame(seg_tab[f % 10], seg_tab[(f / 10) % 10], 5, tt);
            if (f == 254) chk("wrap_255", bus.frame_cnt, 255);
        end
        k = 255;
        chk("wrap_zero", bus.frame_cnt, 0);
        chk("wrap_valids", n_valid - v0, 256);
        chk("wrap_value", bus.value, ((k / 10) % 10) * 10 + (k % 10));
        chk("pulses_exclusive", n_multi, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
